// File: rtl/m_table_loader_if.sv
// Bus bundle for the 1/m table loader: start request in, table write strobe,
// address, data and status out.
interface m_table_loader_if #(
    parameter int AW = 11,
    parameter int W  = 32
) ();
    logic          start;
    logic          setup;
    logic [AW-1:0] write_addr_o;
    logic [W-1:0]  mt_data_o;
    logic          busy_o;
    logic          done_o;

    // Requester side: issues start, watches writes and status
    modport master (
        output start,
        input  setup, write_addr_o, mt_data_o, busy_o, done_o
    );

    // Loader side
    modport slave (
        input  start,
        output setup, write_addr_o, mt_data_o, busy_o, done_o
    );
endinterface

// File: rtl/m_table_loader.sv
// Generates a reciprocal table: entry i = ceil(2^W / i), entry 0 = 0,
// entry 1 = all-ones. One radix-2 restoring division (W+1 steps) per entry,
// followed by a single write cycle, so each entry costs W+2 cycles.
module m_table_loader #(
    parameter int BUFFER_DEPTH  = 2048,
    parameter int M_TABLE_WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    m_table_loader_if.slave mt
);
    localparam int AW = $clog2(BUFFER_DEPTH);
    localparam int W  = M_TABLE_WIDTH;
    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DIV   = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [AW-1:0] LAST_IDX = AW'(BUFFER_DEPTH - 1);

    logic [1:0]    r_state;
    logic [AW-1:0] r_idx;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_rem;   // partial remainder, always < divisor
    logic [W-1:0]  r_quo;   // quotient bits shifted in so far
    logic [AW-1:0] r_addr;
    logic [W-1:0]  r_data;
    logic          r_busy;
    logic          r_done;

    logic          w_bit;
    logic [AW:0]   w_trial;
    logic          w_ge;
    logic [AW:0]   w_rem_nxt;
    logic [W:0]    w_quo_nxt;
    logic          w_last_step;
    logic [W-1:0]  w_val;

    // One restoring-division step; on the last step also forms the rounded-up entry
    always_comb begin
        // Dividend 2^W: only its MSB (consumed on step 0) is set
        w_bit       = (r_cnt == '0);
        w_trial     = {r_rem, w_bit};
        w_ge        = (w_trial >= {1'b0, r_idx});
        w_rem_nxt   = w_ge ? (w_trial - {1'b0, r_idx}) : w_trial;
        w_quo_nxt   = {r_quo, w_ge};
        w_last_step = (r_cnt == CW'(W));
        w_val       = w_quo_nxt[W-1:0] + W'(w_rem_nxt != '0);
        // Slot 0 is the divide-by-zero entry; slot 1 (quotient 2^W) saturates
        if (r_idx == '0)
            w_val = '0;
        else if (r_idx == AW'(1) || w_quo_nxt[W])
            w_val = '1;
    end

    // Sequencer: start handling, divider iteration, per-entry write and completion
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (mt.start) begin
                        r_state <= S_DIV;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_quo   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nxt[AW-1:0];
                    r_quo <= w_quo_nxt[W-1:0];
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last_step) begin
                        r_state <= S_WRITE;
                        r_addr  <= r_idx;
                        r_data  <= w_val;
                    end
                end
                S_WRITE: begin
                    r_cnt <= '0;
                    r_rem <= '0;
                    r_quo <= '0;
                    if (r_idx == LAST_IDX) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx   <= r_idx + AW'(1);
                        r_state <= S_DIV;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mt.setup        = (r_state == S_WRITE);
    assign mt.write_addr_o = r_addr;
    assign mt.mt_data_o    = r_data;
    assign mt.busy_o       = r_busy;
    assign mt.done_o       = r_done;
endmodule

// File: tb/tb_m_table_loader.sv
// Bench for m_table_loader: an 8-entry instance exercised with randomized
// start/reset timing, and a full 2048-entry instance checked end to end.
module tb_m_table_loader;
    localparam int W  = 32;
    localparam int DS = 8;
    localparam int DL = 2048;
    localparam int LAT = W + 2;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    m_table_loader_if #(.AW(3),  .W(W)) s_if ();
    m_table_loader_if #(.AW(11), .W(W)) l_if ();

    m_table_loader #(.BUFFER_DEPTH(DS), .M_TABLE_WIDTH(W)) u_small (
        .clk(clk), .reset(reset), .mt(s_if));
    m_table_loader #(.BUFFER_DEPTH(DL), .M_TABLE_WIDTH(W)) u_large (
        .clk(clk), .reset(reset), .mt(l_if));

    // Reference: ceil(2^W / n), slot 0 = 0, slot 1 saturated
    function automatic logic [63:0] ref_val(input int n);
        logic [63:0] full;
        full = 64'd1 << W;
        if (n == 0) return 64'd0;
        if (n == 1) return full - 64'd1;
        return (full + 64'(n) - 64'd1) / 64'(n);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Write log of the small instance
    int          s_cyc[$];
    logic [63:0] s_adr[$];
    logic [63:0] s_dat[$];
    always @(negedge clk) begin
        if (s_if.setup === 1'b1) begin
            s_cyc.push_back(cyc);
            s_adr.push_back(64'(s_if.write_addr_o));
            s_dat.push_back(64'(s_if.mt_data_o));
        end
    end

    // Online checker for the large instance
    int          l_c0 = 0;
    int          l_cnt = 0;
    int          l_err = 0;
    logic [63:0] l_last = '0;
    always @(negedge clk) begin
        if (l_if.setup === 1'b1) begin
            if (cyc != l_c0 + LAT * (l_cnt + 1) ||
                64'(l_if.write_addr_o) != 64'(l_cnt) ||
                64'(l_if.mt_data_o) != ref_val(l_cnt))
                l_err++;
            if (l_cnt == DL - 1) l_last = 64'(l_if.mt_data_o);
            l_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        s_cyc.delete();
        s_adr.delete();
        s_dat.delete();
    endtask

    task automatic pulse_s(output int c);
        step();
        s_if.start = 1'b1;
        c = cyc;
        step();
        s_if.start = 1'b0;
    endtask

    task automatic wait_done_s(input int budget, output int dc);
        dc = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (s_if.done_o === 1'b1) begin
                dc = cyc;
                break;
            end
        end
    endtask

    task automatic verify_s(input string tag, input int c0, input int n_exp);
        chk($sformatf("%s_count", tag), 64'(s_cyc.size()), 64'(n_exp));
        for (int n = 0; n < s_cyc.size() && n < n_exp; n++) begin
            chk($sformatf("%s_cyc%0d", tag, n), 64'(s_cyc[n]), 64'(c0 + LAT * (n + 1)));
            chk($sformatf("%s_adr%0d", tag, n), s_adr[n], 64'(n));
            chk($sformatf("%s_dat%0d", tag, n), s_dat[n], ref_val(n));
        end
    endtask

    initial begin
        int c0, c1, dc, rc, t, n_exp;
        reset = 1'b1;
        s_if.start = 1'b0;
        l_if.start = 1'b0;

        // Reset state
        repeat (3) step();
        @(negedge clk);
        chk("rst_setup", 64'(s_if.setup), 64'd0);
        chk("rst_busy",  64'(s_if.busy_o), 64'd0);
        chk("rst_done",  64'(s_if.done_o), 64'd0);
        chk("rst_addr",  64'(s_if.write_addr_o), 64'd0);
        chk("rst_data",  64'(s_if.mt_data_o), 64'd0);
        chk("rst_ldone", 64'(l_if.done_o), 64'd0);
        step();
        reset = 1'b0;
        repeat ($urandom_range(1, 5)) step();

        // Full run with a stray start landing in DIV or WRITE
        clear_log();
        pulse_s(c0);
        @(negedge clk);
        chk("run1_busy_c1", 64'(s_if.busy_o), 64'd1);
        t = c0 + LAT * $urandom_range(0, 6) + $urandom_range(1, LAT);
        #1;
        while (cyc < t) step();
        s_if.start = 1'b1;
        step();
        s_if.start = 1'b0;
        wait_done_s(400, dc);
        chk("run1_done_cyc", 64'(dc), 64'(c0 + LAT * DS + 1));
        chk("run1_busy_end", 64'(s_if.busy_o), 64'd0);
        verify_s("run1", c0, DS);
        if (s_dat.size() == DS) begin
            chk("k_addr0", s_dat[0], 64'h0000_0000);
            chk("k_addr1", s_dat[1], 64'hFFFF_FFFF);
            chk("k_addr2", s_dat[2], 64'h8000_0000);
            chk("k_addr3", s_dat[3], 64'h5555_5556);
            chk("k_addr7", s_dat[7], 64'h2492_4925);
        end
        repeat (5) step();
        @(negedge clk);
        chk("hold_setup", 64'(s_if.setup), 64'd0);
        chk("hold_addr",  64'(s_if.write_addr_o), 64'(DS - 1));
        chk("hold_data",  64'(s_if.mt_data_o), ref_val(DS - 1));
        chk("hold_done",  64'(s_if.done_o), 64'd1);

        // Restart from DONE
        repeat ($urandom_range(0, 4)) step();
        clear_log();
        pulse_s(c0);
        @(negedge clk);
        chk("run2_done_clr", 64'(s_if.done_o), 64'd0);
        chk("run2_busy",     64'(s_if.busy_o), 64'd1);
        wait_done_s(400, dc);
        chk("run2_done_cyc", 64'(dc), 64'(c0 + LAT * DS + 1));
        verify_s("run2", c0, DS);

        // Reset in the middle of a run, then regenerate
        step();
        clear_log();
        pulse_s(c0);
        rc = c0 + $urandom_range(40, 260);
        while (cyc < rc) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_busy",  64'(s_if.busy_o), 64'd0);
        chk("mrst_done",  64'(s_if.done_o), 64'd0);
        chk("mrst_setup", 64'(s_if.setup), 64'd0);
        n_exp = 0;
        for (int n = 0; n < DS; n++)
            if (c0 + LAT * (n + 1) <= rc) n_exp++;
        #1;
        while (cyc < rc + 9) step();
        verify_s("mrst", c0, n_exp);
        clear_log();
        pulse_s(c1);
        chk("mrst_start_cyc", 64'(c1), 64'(rc + 10));
        wait_done_s(400, dc);
        chk("rerun_done_cyc", 64'(dc), 64'(c1 + LAT * DS + 1));
        verify_s("rerun", c1, DS);

        // start and reset together: reset wins
        step();
        clear_log();
        s_if.start = 1'b1;
        reset = 1'b1;
        step();
        s_if.start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("sr_busy", 64'(s_if.busy_o), 64'd0);
        chk("sr_done", 64'(s_if.done_o), 64'd0);
        repeat (2 * LAT) step();
        chk("sr_no_pulse", 64'(s_cyc.size()), 64'd0);

        // Full-size table
        step();
        l_if.start = 1'b1;
        l_c0 = cyc;
        step();
        l_if.start = 1'b0;
        dc = -1;
        for (int k = 0; k < LAT * DL + 100; k++) begin
            @(negedge clk);
            if (l_if.done_o === 1'b1) begin
                dc = cyc;
                break;
            end
        end
        chk("big_done_cyc", 64'(dc), 64'(l_c0 + LAT * DL + 1));
        chk("big_count",    64'(l_cnt), 64'(DL));
        chk("big_errors",   64'(l_err), 64'd0);
        chk("big_addr2047", l_last, 64'h0020_0401);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/m_table_loader.md
M_TABLE_LOADER -- requirements
Module: m_table_loader

Interface
REQ-001 SHALL have parameter BUFFER_DEPTH, default 2048, meaning number of 1/m table entries; address width AW = $clog2(BUFFER_DEPTH).
REQ-002 SHALL have parameter M_TABLE_WIDTH, default 32, meaning entry width W; all W bits fractional.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to (re)generate the full table.
REQ-006 SHALL have port setup  output  1  write strobe to the table; high for exactly one cycle per entry.
REQ-007 SHALL have port write_addr_o  output  AW  table address, valid while setup=1.
REQ-008 SHALL have port mt_data_o  output  W  entry value, valid while setup=1.
REQ-009 SHALL have port busy_o  output  1  high from the cycle after an accepted start until the last write cycle inclusive.
REQ-010 SHALL have port done_o  output  1  sticky level: table fully written.

Function
REQ-011 SHALL implement FSM states IDLE, DIV, WRITE, DONE; IDLE and DONE behave identically except done_o.
REQ-012 start sampled high in IDLE or DONE SHALL clear done_o, load entry index i=0, and enter DIV next cycle; start in DIV/WRITE SHALL be ignored.
REQ-013 DIV SHALL run a radix-2 restoring divider of dividend 2^W by divisor i, one quotient bit per cycle, exactly W+1 cycles per entry, independent of i.
REQ-014 Divider SHALL produce floor quotient q (W+1 bits) and remainder r; entry value = q + (r != 0), i.e. ceil(2^W / i), rounded up, never to nearest or down.
REQ-015 Entry 0 SHALL be written as 0 (division-by-zero slot); divider result ignored.
REQ-016 Entry 1 SHALL be written as all-ones (2^W saturated to W bits); divider result ignored.
REQ-017 For i >= 2 the value fits in W bits and SHALL be written unsaturated.
REQ-018 After W+1 DIV cycles the FSM SHALL enter WRITE for one cycle: setup=1, write_addr_o=i, mt_data_o=entry value.
REQ-019 From WRITE, if i == BUFFER_DEPTH-1 go to DONE, else increment i and return to DIV; i SHALL NOT wrap.
REQ-020 Per-entry latency SHALL be W+2 cycles; with start high in cycle 0, entry n SHALL be written in cycle (W+2)*(n+1).
REQ-021 done_o SHALL rise the cycle after the final WRITE, stay high until next accepted start or reset; busy_o low in the same cycle.
REQ-022 setup SHALL be 0 in every state except WRITE; write_addr_o and mt_data_o SHALL hold last written values outside WRITE.
REQ-023 start and reset high in the same cycle: reset SHALL win.

Reset
REQ-024 reset SHALL, in the next cycle, force state IDLE, i=0, setup=0, busy_o=0, done_o=0, write_addr_o=0, mt_data_o=0, clear divider registers.
REQ-025 reset mid-DIV or mid-WRITE SHALL abort with no further setup pulses; a partially written table is accepted; a new start regenerates from entry 0.

Verification
REQ-026 BUFFER_DEPTH=8, W=32, start pulse cycle 0 -> setup pulses at cycles 34,68,...,272 with addresses 0..7; done_o=1 at cycle 273; exactly 8 pulses.
REQ-027 Value check W=32 -> addr0=0x00000000, addr1=0xFFFFFFFF, addr2=0x80000000, addr3=0x55555556, addr7=0x24924925.
REQ-028 BUFFER_DEPTH=2048, W=32 -> addr 2047 = 0x00200401 (remainder nonzero, rounded up), done_o rises cycle 69633.
REQ-029 Reset asserted at cycle 100 of a BUFFER_DEPTH=8 run -> no setup after cycle 100, busy_o=done_o=0 at 101; start at 110 -> addr0 written at cycle 144.
REQ-030 start re-pulsed during DIV and again in DONE -> first ignored (pulse count unchanged); second clears done_o next cycle and rewrites all entries.
